fifo_pack_wr: RTL and testbench

Write-side producer for the design's async FIFOs: packs a continuous narrow sample stream, which cannot be stalled, into wide FIFO words and drives the FIFO's `wr_data`/`we`. It honours the FIFO's registered almost-full flag and drops whole packets instead of overflowing. It sits in the sample-clock domain, directly in front of the FIFO write port.

---
 rtl/fifo_pack_wr.sv | 140 ++++++++++++++
 tb/tb_fifo_pack_wr.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_pack_wr.sv
// ----------------------------------------------------------------------------
// fifo_pack_wr
//
// Write-side producer for an async FIFO. Packs a continuous, unstallable
// stream of narrow samples into wide FIFO words and drives the FIFO write
// port. When the FIFO's registered almost-full flag is high at the moment a
// word closes, the rest of the current packet is dropped rather than
// overflowing the FIFO.
//
// Word layout (W = 1 + LANEBITS + RATIO*INWIDTH):
//   [W-1]                 LAST flag
//   [W-2 -: LANEBITS]     lanes_used - 1
//   [k*INWIDTH +: INWIDTH] sample k (sample 0 arrives first), unused lanes 0
//
// Ports:
//   clk         sample clock
//   reset_l     asynchronous, active-low reset
//   in_data     sample
//   in_valid    sample qualifier (no backpressure)
//   in_last     sample ends a packet (qualified by in_valid)
//   wr_data     packed word to the FIFO, registered, held when we = 0
//   we          FIFO write strobe, registered single-cycle pulse
//   full        FIFO registered almost-full flag
//   drop_count  saturating count of dropped packets, registered
//   dropping    high while the rest of a packet is being discarded
//
// Configuration macro:
//   FIFO_PACK_STATS_EN  defined: drop_count is a saturating counter.
//                       undefined: drop_count is tied to 0.
// ----------------------------------------------------------------------------
module fifo_pack_wr #(
    parameter int INWIDTH  = 16,
    parameter int RATIO    = 2,
    parameter int LANEBITS = 1,
    parameter int CNTWIDTH = 16,
    localparam int W       = 1 + LANEBITS + RATIO * INWIDTH
) (
    input  logic                clk,
    input  logic                reset_l,
    input  logic [INWIDTH-1:0]  in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic [W-1:0]        wr_data,
    output logic                we,
    input  logic                full,
    output logic [CNTWIDTH-1:0] drop_count,
    output logic                dropping
);

    typedef enum logic {
        PASS = 1'b0,
        DROP = 1'b1
    } state_t;

    state_t                     state;
    logic [RATIO*INWIDTH-1:0]   lanes;
    logic [LANEBITS-1:0]        lane_ptr;

    logic [RATIO*INWIDTH-1:0]   next_lanes;
    logic                       closing;
    logic [W-1:0]               word;

    // Lanes including the current sample, and whether this sample closes
    // the word (lane RATIO-1 filled, or end of packet).
    // NOTE: every combinational output gets a default first so no latch is
    // inferred when the sample is not valid.
    always_comb begin
        next_lanes = lanes;
        for (int k = 0; k < RATIO; k++) begin
            if (lane_ptr == LANEBITS'(k)) begin
                next_lanes[k*INWIDTH +: INWIDTH] = in_data;
            end
        end
        closing = in_valid && (in_last || (lane_ptr == LANEBITS'(RATIO - 1)));
        // lane_ptr of the closing sample equals lanes_used - 1.
        word    = {in_last, lane_ptr, next_lanes};
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state    <= PASS;
            lanes    <= '0;
            lane_ptr <= '0;
            wr_data  <= '0;
            we       <= 1'b0;
            dropping <= 1'b0;
        end else begin
            we <= 1'b0;
            if (closing) begin
                // Lanes are cleared on every close so unused lanes of the
                // next word read 0.
                lanes    <= '0;
                lane_ptr <= '0;
                case (state)
                    PASS: begin
                        if (!full) begin
                            we      <= 1'b1;
                            wr_data <= word;
                        end else if (!in_last) begin
                            // Rest of this packet must not reach the FIFO.
                            state    <= DROP;
                            dropping <= 1'b1;
                        end
                    end
                    DROP: begin
                        // The packet's LAST word is discarded too; the count
                        // was already taken when the drop started.
                        if (in_last) begin
                            state    <= PASS;
                            dropping <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= PASS;
                        dropping <= 1'b0;
                    end
                endcase
            end else if (in_valid) begin
                lanes    <= next_lanes;
                lane_ptr <= lane_ptr + 1'b1;
            end
        end
    end

`ifdef FIFO_PACK_STATS_EN
    // One count per dropped packet: taken only on the PASS-state decision.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            drop_count <= '0;
        end else if (closing && (state == PASS) && full && (drop_count != '1)) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_fifo_pack_wr.sv
// ----------------------------------------------------------------------------
// tb_fifo_pack_wr
//
// Directed bench for fifo_pack_wr. Two instances share all inputs: dut with
// default parameters, and dut_sat with CNTWIDTH = 2 for counter saturation.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, so they reflect the edge that just happened.
// ----------------------------------------------------------------------------
module tb_fifo_pack_wr;

    localparam int INWIDTH = 16;
    localparam int W       = 34;

`ifdef FIFO_PACK_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic               clk = 1'b0;
    logic               reset_l;
    logic [INWIDTH-1:0] in_data;
    logic               in_valid;
    logic               in_last;
    logic               full;

    logic [W-1:0]       wr_data;
    logic               we;
    logic [15:0]        drop_count;
    logic               dropping;

    logic [W-1:0]       wr_data_s;
    logic               we_s;
    logic [1:0]         drop_count_s;
    logic               dropping_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_pack_wr dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .wr_data    (wr_data),
        .we         (we),
        .full       (full),
        .drop_count (drop_count),
        .dropping   (dropping)
    );

    fifo_pack_wr #(.CNTWIDTH(2)) dut_sat (
        .clk        (clk),
        .reset_l    (reset_l),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .wr_data    (wr_data_s),
        .we         (we_s),
        .full       (full),
        .drop_count (drop_count_s),
        .dropping   (dropping_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One valid sample, then deassert valid; outputs then show that edge.
    task automatic send(input logic [INWIDTH-1:0] d, input logic last);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_l  = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        full     = 1'b0;

        // Reset state
        #2;
        check("rst_we", we, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_dropping", dropping, 0);
        idle(2);
        reset_l = 1'b1;
        idle(1);

        // Two-sample packet, LAST coincides with filling the last lane
        send(16'h1111, 1'b0);
        check("t1_no_we_mid", we, 0);
        send(16'h2222, 1'b1);
        check("t1_we", we, 1);
        check("t1_data", wr_data, 34'h3_2222_1111);
        idle(1);
        check("t1_we_pulse", we, 0);
        check("t1_data_hold", wr_data, 34'h3_2222_1111);

        // Three samples with valid gaps: a full word then a one-lane LAST word
        send(16'h000A, 1'b0);
        idle(2);
        check("t2_gap_no_we", we, 0);
        send(16'h000B, 1'b0);
        check("t2_w0_we", we, 1);
        check("t2_w0_data", wr_data, 34'h1_000B_000A);
        idle(1);
        check("t2_gap2_no_we", we, 0);
        send(16'h000C, 1'b1);
        check("t2_w1_we", we, 1);
        check("t2_w1_data", wr_data, 34'h2_0000_000C);

        // Three-word packet, full on the first close: whole remainder dropped
        send(16'h0101, 1'b0);
        full = 1'b1;
        send(16'h0102, 1'b0);
        full = 1'b0;
        check("t3_w0_no_we", we, 0);
        check("t3_w0_dropping", dropping, 1);
        check("t3_count", drop_count, STATS);
        send(16'h0103, 1'b0);
        send(16'h0104, 1'b0);
        check("t3_w1_no_we", we, 0);
        check("t3_w1_dropping", dropping, 1);
        send(16'h0105, 1'b0);
        check("t3_mid_dropping", dropping, 1);
        send(16'h0106, 1'b1);
        check("t3_w2_no_we", we, 0);
        check("t3_end_dropping", dropping, 0);
        check("t3_count_once", drop_count, STATS);
        send(16'h0007, 1'b0);
        send(16'h0008, 1'b1);
        check("t3_next_we", we, 1);
        check("t3_next_data", wr_data, 34'h3_0008_0007);
        check("t3_next_count", drop_count, STATS);

        // Asynchronous reset mid-packet
        send(16'h0099, 1'b0);
        #2;
        reset_l = 1'b0;
        #1;
        check("t4_rst_we", we, 0);
        check("t4_rst_data", wr_data, 0);
        check("t4_rst_count", drop_count, 0);
        check("t4_rst_dropping", dropping, 0);
        @(posedge clk);
        #1;
        reset_l = 1'b1;
        send(16'h0005, 1'b0);
        check("t4_no_we_mid", we, 0);
        send(16'h0006, 1'b1);
        check("t4_we", we, 1);
        check("t4_data", wr_data, 34'h3_0006_0005);

        // Five single-word packets dropped; 2-bit counter saturates at 3
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(16'h00E0 + 16'(i), 1'b1);
            check("t5_no_we", we, 0);
            check("t5_not_dropping", dropping, 0);
        end
        check("t5_count16", drop_count, 5 * STATS);
        check("t5_count_sat", drop_count_s, 3 * STATS);
        full = 1'b0;
        send(16'h0042, 1'b1);
        check("t5_after_we", we, 1);
        check("t5_after_data", wr_data, 34'h2_0000_0042);
        check("t5_sat_hold", drop_count_s, 3 * STATS);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
